// File: rtl/mcpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches through the RAM instruction port and buffers {word, pc} pairs.
// Latency: a word fetched in cycle N is presented to the decoder in cycle N+1; sustained 1 word/cycle.
// Backpressure: instr_ready=0 holds the head; a full FIFO without a pop stalls fetch and freezes the PC.
module mcpu_fetch_unit #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [ADDR_WIDTH-1:0]         instraddr,
  input  logic [WORD_SIZE-1:0]          instrrd,
  input  logic                          redirect,
  input  logic [ADDR_WIDTH-1:0]         redirect_addr,
  input  logic                          halt,
  output logic                          instr_valid,
  output logic [WORD_SIZE-1:0]          instr,
  output logic [ADDR_WIDTH-1:0]         instr_pc,
  input  logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Architectural state: PC, FIFO pointers and occupancy.
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]      count, count_nxt;

  // Prefetch storage; word and its fetch address live side by side.
  logic [WORD_SIZE-1:0]  word_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];

  logic full;
  logic pop;
  logic push;

  // The RAM address comes straight from a register, so there is no input-to-instraddr path.
  assign instraddr   = fetch_pc;
  assign fifo_count  = count;
  assign instr_valid = (count != '0);
  assign instr       = word_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  assign full = (count == FULL_CNT);
  assign pop  = instr_valid & instr_ready;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign push = ~redirect & ~halt & (~full | pop);

  // Next-state for PC, pointers and count; redirect flushes everything and wins over push/pop.
  always_comb begin
    fetch_pc_nxt = fetch_pc;
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    count_nxt    = count;
    if (redirect) begin
      // A pop this cycle still completes for the decoder; the flush discards whatever remains.
      fetch_pc_nxt = redirect_addr;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
    end else begin
      if (push) begin
        fetch_pc_nxt = fetch_pc + 1'b1;
        wr_ptr_nxt   = wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_nxt = count + 1'b1;
      end else if (pop && !push) begin
        count_nxt = count - 1'b1;
      end
    end
  end

  // State register; reset dominates redirect and every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
    end
  end

  // Tail write of the fetched word with the address it came from; cleared on reset so the idle head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      word_mem[wr_ptr] <= instrrd;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: doc/mcpu_fetch_unit.md
Name: mcpu_fetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder and client of the RAM controller's instruction read port. Owns the program counter. Drives instraddr and samples the combinational instrrd. Buffers fetched words with their PCs in a small prefetch FIFO, presented to the decoder through a valid/ready handshake, with flush-and-redirect for taken branches and a halt input.

Parameters:
WORD_SIZE, 8, instruction word width; matches the RAM controller.
ADDR_WIDTH, 8, PC / instruction address width; matches the RAM controller.
FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
instraddr  output  ADDR_WIDTH  to RAM controller instraddr; equals fetch_pc register.
instrrd  input  WORD_SIZE  from RAM controller instrrd; combinational read of mem[instraddr].
redirect  input  1  taken branch/jump; flush and reload PC.
redirect_addr  input  ADDR_WIDTH  new fetch address, sampled when redirect=1.
halt  input  1  stop fetching new words; FIFO keeps draining.
instr_valid  output  1  FIFO head holds a valid instruction.
instr  output  WORD_SIZE  FIFO head instruction word.
instr_pc  output  ADDR_WIDTH  address the head word was fetched from.
instr_ready  input  1  decoder accepts the head this cycle.
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries, 0..FIFO_DEPTH.

Behaviour:
- Reset, sampled at clk edge while reset=1, overrides all other inputs, including mid-operation. Reset values: fetch_pc=0, so instraddr=0. FIFO storage=0, so instr=0 and instr_pc=0. fifo_count=0 and instr_valid=0.
- instraddr is driven straight from the fetch_pc register, with no combinational path from any input.
- pop = instr_valid & instr_ready. The decoder holds the head whenever instr_ready=0.
- push = ~redirect & ~halt & (fifo_count<FIFO_DEPTH | pop).
- On push: write {instrrd, fetch_pc} at the tail, and set fetch_pc <= fetch_pc+1 modulo 2^ADDR_WIDTH. The PC wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
- Count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
- Full (count=FIFO_DEPTH) without pop: no push, fetch_pc holds.
- Full with pop: push occurs in the same cycle.
- Empty: instr_valid=0. instr and instr_pc hold the last head-slot contents and are don't-care.
- Latency: a word fetched at address A in cycle N is visible at instr/instr_pc with instr_valid=1 in cycle N+1. Sustained throughput is 1 word/cycle when instr_ready stays 1.
- Redirect, at the clk edge with redirect=1:
  - FIFO is flushed (count=0, pointers reset) and fetch_pc <= redirect_addr. No push occurs.
  - A pop in that same cycle completes from the decoder's view, but no word is retained.
  - The next cycle has instraddr=redirect_addr and instr_valid=0. The target word is valid one cycle after that.
- Redirect has priority over halt. Redirect together with halt still flushes and loads the PC, and fetching stays stopped while halt=1.
- Halt: no push and fetch_pc holds. Pops continue until the FIFO is empty. Deasserting halt resumes fetching at the held fetch_pc.
- Prefetched words are not snooped against data-port writes. A store to an address already in the FIFO does not update it; software issues a redirect to refetch.
- The block is internally a state machine of PC plus FIFO pointers. No other sequencing states exist.

Test Plan:
1. Reset with RAM mem[i]=i^8'hA5 and instr_ready=1. Expected: instraddr=0 and instr_valid=0 in the first cycle after reset; then instr/instr_pc = A5/00, A4/01, A7/02 on consecutive cycles.
2. Backpressure: instr_ready=0 for 10 cycles from the start. Expected: fifo_count saturates at 4 and instraddr holds at 4. With instr_ready=1, instr_pc runs 0,1,2,3,4,5 with no gaps or duplicates.
3. Redirect: pulse redirect with redirect_addr=8'h40 while the FIFO holds 3 entries. Expected: next cycle fifo_count=0, instr_valid=0, instraddr=40. The cycle after that, instr_pc=40 and instr=mem[40].
4. Wrap: redirect to 8'hFE with ready=1. Expected: instr_pc sequence FE, FF, 00, 01.
5. Halt: assert halt with 2 entries buffered and ready=1. Expected: two pops, then instr_valid=0 and instraddr frozen. Release halt: fetching resumes from the frozen address.
6. Reset mid-stream: assert reset with count=3 and redirect=1 on the same edge. Expected: all outputs take reset values and instraddr=0, not redirect_addr.
